gpu_vtg: RTL and testbench

GPU_VTG -- requirements
Module: gpu_vtg

---
 rtl/gpu_video_pkg.sv | 62 ++++++
 rtl/gpu_vtg_if.sv | 23 ++
 rtl/gpu_vtg_fetch.sv | 80 ++++++++
 rtl/gpu_vtg.sv | 120 ++++++++++++
 tb/tb_gpu_vtg.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_video_pkg.sv
// Shared video timing definitions: preset constants, timing derivations and
// the line-fetch state encoding used by gpu_vtg.
package gpu_video_pkg;

    localparam int unsigned CNT_W  = 12;
    localparam int unsigned ADDR_W = 11;

    typedef struct packed {
        logic [CNT_W-1:0] h_disp;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_disp;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
    } vtg_timing_t;

    // 640x480@60, 25.2 MHz pixel clock
    localparam vtg_timing_t VTG_640X480_60 = '{
        h_disp: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_disp: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33
    };

    // 640x480 on a 25.0 MHz pixel clock, shortened vertical back porch
    localparam vtg_timing_t VTG_640X480_25M = '{
        h_disp: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_disp: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd29
    };

    // 1024x768@75, 78.75 MHz pixel clock
    localparam vtg_timing_t VTG_1024X768_75 = '{
        h_disp: 12'd1024, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd176,
        v_disp: 12'd768,  v_fp: 12'd1,  v_sync: 12'd3,  v_bp: 12'd28
    };

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_t;

    function automatic int unsigned h_total(input int unsigned disp, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned disp, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int unsigned h_start(input int unsigned fp, input int unsigned sync,
                                            input int unsigned bp);
        return fp + sync + bp;
    endfunction

    function automatic int unsigned v_start(input int unsigned fp, input int unsigned sync,
                                            input int unsigned bp);
        return fp + sync + bp;
    endfunction

endpackage

// File: rtl/gpu_vtg_if.sv
// Line-buffer side of the timing generator: pixel read port and line-fetch handshake.
interface gpu_vtg_if #(
    parameter int unsigned BPC = 1
);
    import gpu_video_pkg::*;

    logic [ADDR_W-1:0]  pix_addr;
    logic [3*BPC-1:0]   pix_data;
    logic               line_req;
    logic [ADDR_W-1:0]  line_num;
    logic               line_ack;

    modport master (
        output pix_addr, line_req, line_num,
        input  pix_data, line_ack
    );

    modport slave (
        input  pix_addr, line_req, line_num,
        output pix_data, line_ack
    );

endinterface

// File: rtl/gpu_vtg_fetch.sv
// Line-fetch requester: asks for each new source line at the start of the
// line and flags a sticky underrun if the buffer has not answered by active video.
module gpu_vtg_fetch
    import gpu_video_pkg::*;
#(
    parameter int unsigned H_START    = 160,
    parameter int unsigned V_START    = 45,
    parameter int unsigned SCALE_LOG2 = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [CNT_W-1:0]  hc,
    input  logic [CNT_W-1:0]  vc,
    input  logic              line_ack,
    input  logic              clr_underrun,
    output logic              line_req,
    output logic [ADDR_W-1:0] line_num,
    output logic              underrun
);

    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] ROW_MASK  = CNT_W'((1 << SCALE_LOG2) - 1);

    fetch_state_t     state;
    logic [CNT_W-1:0] row_c;
    logic             start_c;
    logic             timeout_c;

    // A new source line begins only on rows that are not repeats of a scaled line
    always_comb begin
        row_c     = vc - V_START_C;
        start_c   = (hc == '0) && (vc >= V_START_C) && ((row_c & ROW_MASK) == '0);
        timeout_c = en && (state == FETCH_REQ) && !line_ack && (hc == H_START_C);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= FETCH_IDLE;
            line_req <= 1'b0;
            line_num <= '0;
            underrun <= 1'b0;
        end else begin
            if (timeout_c) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end

            if (!en) begin
                state    <= FETCH_IDLE;
                line_req <= 1'b0;
                line_num <= '0;
            end else begin
                case (state)
                    FETCH_IDLE: begin
                        if (start_c) begin
                            state    <= FETCH_REQ;
                            line_req <= 1'b1;
                            line_num <= ADDR_W'(row_c >> SCALE_LOG2);
                        end
                    end
                    FETCH_REQ: begin
                        // An ack on the deadline cycle still counts as in time
                        if (line_ack || (hc == H_START_C)) begin
                            state    <= FETCH_IDLE;
                            line_req <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= FETCH_IDLE;
                        line_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/gpu_vtg.sv
// Video timing generator: h/v counters, two-stage pixel pipeline (address, then
// colour) and the line-fetch requester for the external line buffer.
module gpu_vtg
    import gpu_video_pkg::*;
#(
    parameter int unsigned H_DISP     = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_DISP     = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned BPC        = 1,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    gpu_vtg_if.master        vbus,
    output logic [3*BPC-1:0] rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic             underrun,
    input  logic             clr_underrun
);

    localparam int unsigned H_START = h_start(H_FP, H_SYNC, H_BP);
    localparam int unsigned V_START = v_start(V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST_C     = CNT_W'(h_total(H_DISP, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST_C     = CNT_W'(v_total(V_DISP, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_START_C    = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] V_START_C    = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] H_FP_C       = CNT_W'(H_FP);
    localparam logic [CNT_W-1:0] V_FP_C       = CNT_W'(V_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END_C = CNT_W'(H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END_C = CNT_W'(V_FP + V_SYNC);

    logic [CNT_W-1:0]  hc;
    logic [CNT_W-1:0]  vc;
    logic              act_c;
    logic              hs_c;
    logic              vs_c;
    logic              fs_c;
    logic [ADDR_W-1:0] addr_c;
    logic              de_s1;
    logic              hs_s1;
    logic              vs_s1;
    logic              fs_s1;

    // Raster position; disabling restarts the frame from the top of vertical blanking
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST_C) begin
            hc <= '0;
            vc <= (vc == V_LAST_C) ? '0 : vc + CNT_W'(1);
        end else begin
            hc <= hc + CNT_W'(1);
        end
    end

    always_comb begin
        act_c  = (hc >= H_START_C) && (vc >= V_START_C);
        hs_c   = ((hc >= H_FP_C) && (hc < H_SYNC_END_C)) ? SYNC_POL : ~SYNC_POL;
        vs_c   = ((vc >= V_FP_C) && (vc < V_SYNC_END_C)) ? SYNC_POL : ~SYNC_POL;
        fs_c   = (hc == H_START_C) && (vc == V_START_C);
        addr_c = act_c ? ADDR_W'((hc - H_START_C) >> SCALE_LOG2) : '0;
    end

    // Stage 1 issues the buffer address; stage 2 captures the returned colour
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            vbus.pix_addr <= '0;
            de_s1         <= 1'b0;
            hs_s1         <= ~SYNC_POL;
            vs_s1         <= ~SYNC_POL;
            fs_s1         <= 1'b0;
            rgb           <= '0;
            de            <= 1'b0;
            hsync         <= ~SYNC_POL;
            vsync         <= ~SYNC_POL;
            frame_start   <= 1'b0;
        end else begin
            vbus.pix_addr <= addr_c;
            de_s1         <= act_c;
            hs_s1         <= hs_c;
            vs_s1         <= vs_c;
            fs_s1         <= fs_c;
            rgb           <= de_s1 ? vbus.pix_data : '0;
            de            <= de_s1;
            hsync         <= hs_s1;
            vsync         <= vs_s1;
            frame_start   <= fs_s1;
        end
    end

    gpu_vtg_fetch #(
        .H_START    (H_START),
        .V_START    (V_START),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_fetch (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .hc           (hc),
        .vc           (vc),
        .line_ack     (vbus.line_ack),
        .clr_underrun (clr_underrun),
        .line_req     (vbus.line_req),
        .line_num     (vbus.line_num),
        .underrun     (underrun)
    );

endmodule

// File: tb/tb_gpu_vtg.sv
// Bench for gpu_vtg: two small-raster instances (1x / positive-sync 2x) checked
// every cycle against a position-based reference model with random ack timing.
module tb_gpu_vtg;

    localparam int HFP = 2, HSY = 3, HBP = 3, HD = 16;
    localparam int VFP = 1, VSY = 2, VBP = 2, VD = 8;
    localparam int HS = HFP + HSY + HBP;
    localparam int HT = HS + HD;
    localparam int VS = VFP + VSY + VBP;
    localparam int VT = VS + VD;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        en;
    logic        clr_underrun;
    logic [2:0]  rgb0;
    logic [11:0] rgb1;
    logic        hsync0, vsync0, de0, fs0, ur0;
    logic        hsync1, vsync1, de1, fs1, ur1;

    logic [2:0]  mem0 [2048];
    logic [11:0] mem1 [2048];

    gpu_vtg_if #(.BPC(1)) bus0 ();
    gpu_vtg_if #(.BPC(4)) bus1 ();

    assign bus0.pix_data = mem0[bus0.pix_addr];
    assign bus1.pix_data = mem1[bus1.pix_addr];

    gpu_vtg #(
        .H_DISP(HD), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_DISP(VD), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .BPC(1), .SCALE_LOG2(0), .SYNC_POL(1'b0)
    ) dut0 (
        .clk(clk), .resetn(resetn), .en(en), .vbus(bus0),
        .rgb(rgb0), .hsync(hsync0), .vsync(vsync0), .de(de0),
        .frame_start(fs0), .underrun(ur0), .clr_underrun(clr_underrun)
    );

    gpu_vtg #(
        .H_DISP(HD), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_DISP(VD), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .BPC(4), .SCALE_LOG2(1), .SYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .resetn(resetn), .en(en), .vbus(bus1),
        .rgb(rgb1), .hsync(hsync1), .vsync(vsync1), .de(de1),
        .frame_start(fs1), .underrun(ur1), .clr_underrun(clr_underrun)
    );

    int tests = 0;
    int fails = 0;
    int n;
    int dly [2];
    int ln  [2];
    bit ur  [2];
    bit drv_rstn, drv_en;
    int clr_rate;

    function automatic bit fetch_line(input int v, input int s);
        return (v >= VS) && (((v - VS) % (1 << s)) == 0);
    endfunction

    // Expected request: from pixel 1 of a fetch line until ack or the start of active video
    function automatic bit exp_req(input int i);
        int h, v, s, last;
        s = i;
        h = n % HT;
        v = (n / HT) % VT;
        if (!fetch_line(v, s)) return 1'b0;
        last = (dly[i] + 1 < HS) ? dly[i] + 1 : HS;
        return (h >= 1) && (h <= last);
    endfunction

    function automatic bit ack_now(input int i);
        int h, v;
        h = n % HT;
        v = (n / HT) % VT;
        return fetch_line(v, i) && (dly[i] + 1 < HS) && (h == dly[i] + 1);
    endfunction

    function automatic logic [31:0] pixel(input int i, input int a);
        return (i == 0) ? 32'(mem0[a]) : 32'(mem1[a]);
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d n=%0d observed=%0h expected=%0h", tag, i, n, obs, exp);
        end
    endtask

    task automatic check_dut(input int i);
        int m, h, v, h1, v1;
        bit pol, e_de, e_hs, e_vs, e_fs;
        logic [31:0] e_rgb, e_addr;
        logic [31:0] o_rgb, o_addr, o_ln;
        logic o_hs, o_vs, o_de, o_fs, o_req, o_ur;
        pol = (i == 1);
        if (n < 2) begin
            e_de = 1'b0; e_hs = !pol; e_vs = !pol; e_fs = 1'b0; e_rgb = '0;
        end else begin
            m = n - 2;
            h = m % HT;
            v = (m / HT) % VT;
            e_de  = (h >= HS) && (v >= VS);
            e_hs  = (h >= HFP && h < HFP + HSY) ? pol : !pol;
            e_vs  = (v >= VFP && v < VFP + VSY) ? pol : !pol;
            e_fs  = (h == HS) && (v == VS);
            e_rgb = e_de ? pixel(i, (h - HS) >> i) : '0;
        end
        e_addr = '0;
        if (n >= 1) begin
            h1 = (n - 1) % HT;
            v1 = ((n - 1) / HT) % VT;
            if (h1 >= HS && v1 >= VS) e_addr = 32'((h1 - HS) >> i);
        end
        if (i == 0) begin
            o_rgb = 32'(rgb0); o_addr = 32'(bus0.pix_addr); o_ln = 32'(bus0.line_num);
            o_hs = hsync0; o_vs = vsync0; o_de = de0; o_fs = fs0; o_req = bus0.line_req; o_ur = ur0;
        end else begin
            o_rgb = 32'(rgb1); o_addr = 32'(bus1.pix_addr); o_ln = 32'(bus1.line_num);
            o_hs = hsync1; o_vs = vsync1; o_de = de1; o_fs = fs1; o_req = bus1.line_req; o_ur = ur1;
        end
        chk("rgb",         i, o_rgb,       e_rgb);
        chk("pix_addr",    i, o_addr,      e_addr);
        chk("hsync",       i, 32'(o_hs),   32'(e_hs));
        chk("vsync",       i, 32'(o_vs),   32'(e_vs));
        chk("de",          i, 32'(o_de),   32'(e_de));
        chk("frame_start", i, 32'(o_fs),   32'(e_fs));
        chk("line_req",    i, 32'(o_req),  32'(exp_req(i)));
        chk("line_num",    i, o_ln,        32'(ln[i]));
        chk("underrun",    i, 32'(o_ur),   32'(ur[i]));
    endtask

    // One clock: check outputs, drive inputs at the falling edge, advance the model after the rising edge
    task automatic step();
        int h, v;
        bit ack [2];
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        resetn = drv_rstn;
        en     = drv_en;
        h = n % HT;
        for (int i = 0; i < 2; i++) begin
            if (h == 0) dly[i] = $urandom_range(0, HS + 2);
            ack[i] = ack_now(i);
        end
        bus0.line_ack = ack[0];
        bus1.line_ack = ack[1];
        clr_underrun  = (clr_rate != 0) && ($urandom_range(0, clr_rate - 1) == 0);
        @(posedge clk);
        #1;
        v = (n / HT) % VT;
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                ur[i] = 1'b0;
                ln[i] = 0;
            end else begin
                if (en && exp_req(i) && (h == HS)) ur[i] = 1'b1;
                else if (clr_underrun) ur[i] = 1'b0;
                if (!en) ln[i] = 0;
                else if (h == 0 && fetch_line(v, i)) ln[i] = (v - VS) >> i;
            end
        end
        n = (!resetn || !en) ? 0 : n + 1;
    endtask

    function automatic bit exp_active0();
        return (n >= 2) && (((n - 2) % HT) >= HS) && ((((n - 2) / HT) % VT) >= VS);
    endfunction

    initial begin
        int k;
        for (int a = 0; a < 2048; a++) begin
            mem0[a] = 3'($urandom);
            mem1[a] = 12'($urandom);
        end
        n = 0;
        dly = '{0, 0};
        ln  = '{0, 0};
        ur  = '{1'b0, 1'b0};
        resetn = 1'b0; en = 1'b0; clr_underrun = 1'b0;
        bus0.line_ack = 1'b0; bus1.line_ack = 1'b0;
        drv_rstn = 1'b0; drv_en = 1'b0; clr_rate = 0;

        // reset state
        repeat (3) step();

        // free running, random ack latency, no clears: underruns accumulate
        drv_rstn = 1'b1; drv_en = 1'b1;
        repeat (2 * FRAME) step();

        // frequent clear pulses against the sticky flag
        clr_rate = 40;
        repeat (FRAME) step();
        clr_rate = 0;

        // drop enable while a request is outstanding, then restart from the top
        k = 0;
        while (!exp_req(0) && k < FRAME) begin step(); k++; end
        tests++;
        assert (k < FRAME) else begin
            fails++;
            $error("FAIL wait_req observed=%0d cycles expected=<%0d", k, FRAME);
        end
        drv_en = 1'b0;
        repeat (4) step();
        drv_en = 1'b1;
        repeat (FRAME + HT) step();

        // synchronous reset in the middle of active video
        k = 0;
        while (!exp_active0() && k < FRAME) begin step(); k++; end
        tests++;
        assert (k < FRAME) else begin
            fails++;
            $error("FAIL wait_active observed=%0d cycles expected=<%0d", k, FRAME);
        end
        drv_rstn = 1'b0;
        step();
        drv_rstn = 1'b1;
        clr_rate = 150;
        repeat (FRAME + 2 * HT) step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
